// File: rtl/pc_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit_if
// Instruction-memory request/acknowledge bus between the fetch unit and the
// instruction memory.
//   imem_req   : fetch unit -> memory, a read is outstanding
//   imem_addr  : fetch unit -> memory, word address of the read (stable while
//                imem_req=1 until imem_ack)
//   imem_ack   : memory -> fetch unit, imem_rdata is valid; ends the request
//   imem_rdata : memory -> fetch unit, the instruction word read
// Modports: master (fetch unit side), slave (memory side).
// ----------------------------------------------------------------------------
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
// Instruction fetch stage: keeps the program counter, issues one instruction
// memory read at a time, and presents the fetched word to the IF/ID register.
// Handles load-use stalls (by parking an early-arriving word in a one-entry
// buffer) and redirects from execute (by discarding in-flight data, draining an
// outstanding request first if necessary).
//
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   Jal, Jalr,
//   branch_result       : redirect requests (priority Jalr > Jal > branch)
//   jal_target,
//   jalr_target,
//   branch_target       : redirect addresses (bits [1:0] ignored)
//   load                : load-use stall, fetch outputs hold
//   imem                : instruction-memory bus (master side)
//   instruction_fetch   : fetched instruction
//   pc_pre_address      : address of instruction_fetch
//   fetch_valid         : instruction_fetch holds a real instruction
//
// States
//   FETCH : request at pc outstanding
//   HOLD  : word arrived during a stall, parked in buf_data/buf_pc, no request
//   DRAIN : redirect arrived with a request still outstanding; wait for the
//           ack at the old address, then jump to redir_pc
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Jal,
  input  logic                   Jalr,
  input  logic                   branch_result,
  input  logic [31:0]            jal_target,
  input  logic [31:0]            jalr_target,
  input  logic [31:0]            branch_target,
  input  logic                   load,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            instruction_fetch,
  output logic [31:0]            pc_pre_address,
  output logic                   fetch_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_data;
  logic [31:0] buf_pc;
  logic [31:0] redir_pc;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        ack;

  // Word-align any address that is loaded into pc or redir_pc.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Redirect selection: Jalr beats Jal beats a taken branch.
  always_comb begin
    redirect = Jalr | Jal | branch_result;
    if (Jalr) begin
      redirect_target = word_align(jalr_target);
    end else if (Jal) begin
      redirect_target = word_align(jal_target);
    end else begin
      redirect_target = word_align(branch_target);
    end
  end

  assign pc_plus4 = pc + 32'd4;
  assign ack      = imem.imem_ack;

  // The request address is always pc: in DRAIN pc still holds the old
  // address (the new target waits in redir_pc), in HOLD no request is out.
  // Reset masks the request combinationally so no read is seen while rst=1.
  assign imem.imem_req  = (state != HOLD) && !rst;
  assign imem.imem_addr = pc;

  // Fetch FSM, program counter, stall buffer and registered fetch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= FETCH;
      pc                <= word_align(RESET_PC);
      buf_data          <= 32'd0;
      buf_pc            <= 32'd0;
      redir_pc          <= 32'd0;
      instruction_fetch <= 32'd0;
      pc_pre_address    <= 32'd0;
      fetch_valid       <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            // Whatever is in flight belongs to the wrong path.
            instruction_fetch <= 32'd0;
            pc_pre_address    <= 32'd0;
            fetch_valid       <= 1'b0;
            if (ack) begin
              pc <= redirect_target;
            end else begin
              // Request must complete at the old address before jumping.
              redir_pc <= redirect_target;
              state    <= DRAIN;
            end
          end else if (ack) begin
            pc <= pc_plus4;
            if (load) begin
              // Decode is stalled: park the word until the stall clears.
              buf_data <= imem.imem_rdata;
              buf_pc   <= pc;
              state    <= HOLD;
            end else begin
              instruction_fetch <= imem.imem_rdata;
              pc_pre_address    <= pc;
              fetch_valid       <= 1'b1;
            end
          end else if (!load) begin
            // No data this cycle: bubble.
            instruction_fetch <= 32'd0;
            pc_pre_address    <= 32'd0;
            fetch_valid       <= 1'b0;
          end else begin
            // Stalled and still waiting: outputs hold, request stays up.
            state <= FETCH;
          end
        end

        HOLD: begin
          if (redirect) begin
            pc                <= redirect_target;
            buf_data          <= 32'd0;
            buf_pc            <= 32'd0;
            instruction_fetch <= 32'd0;
            pc_pre_address    <= 32'd0;
            fetch_valid       <= 1'b0;
            state             <= FETCH;
          end else if (!load) begin
            instruction_fetch <= buf_data;
            pc_pre_address    <= buf_pc;
            fetch_valid       <= 1'b1;
            state             <= FETCH;
          end else begin
            state <= HOLD;
          end
        end

        DRAIN: begin
          instruction_fetch <= 32'd0;
          pc_pre_address    <= 32'd0;
          fetch_valid       <= 1'b0;
          if (ack) begin
            // A redirect arriving in the ack cycle is the latest and wins.
            if (redirect) begin
              pc       <= redirect_target;
              redir_pc <= redirect_target;
            end else begin
              pc <= redir_pc;
            end
            state <= FETCH;
          end else if (redirect) begin
            redir_pc <= redirect_target;
          end else begin
            state <= DRAIN;
          end
        end

        default: begin
          state             <= FETCH;
          instruction_fetch <= 32'd0;
          pc_pre_address    <= 32'd0;
          fetch_valid       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed bench for pc_fetch_unit. The instruction memory is modelled by the
// bench driving imem_ack/imem_rdata, with the word at address A defined as
// A ^ 32'hFFFF_FFFF. Inputs change on the falling edge; outputs are sampled on
// the following falling edge, after the rising edge in between.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        Jal;
  logic        Jalr;
  logic        branch_result;
  logic [31:0] jal_target;
  logic [31:0] jalr_target;
  logic [31:0] branch_target;
  logic        load;
  logic [31:0] instruction_fetch;
  logic [31:0] pc_pre_address;
  logic        fetch_valid;

  int vectors;
  int miscompares;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .Jal               (Jal),
    .Jalr              (Jalr),
    .branch_result     (branch_result),
    .jal_target        (jal_target),
    .jalr_target       (jalr_target),
    .branch_target     (branch_target),
    .load              (load),
    .imem              (bus.master),
    .instruction_fetch (instruction_fetch),
    .pc_pre_address    (pc_pre_address),
    .fetch_valid       (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] ppa,
                            input logic [31:0] ins, input logic req, input logic [31:0] addr);
    check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, v});
    check({tag, ".pc_pre_address"}, pc_pre_address, ppa);
    check({tag, ".instruction_fetch"}, instruction_fetch, ins);
    check({tag, ".imem_req"}, {31'd0, bus.imem_req}, {31'd0, req});
    check({tag, ".imem_addr"}, bus.imem_addr, addr);
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic ld,
                       input logic jl, input logic jr, input logic br);
    bus.imem_ack   = ack;
    bus.imem_rdata = rdata;
    load           = ld;
    Jal            = jl;
    Jalr           = jr;
    branch_result  = br;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    jal_target    = 32'd0;
    jalr_target   = 32'd0;
    branch_target = 32'd0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset state.
    expect_out("reset", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

    // Reset release: request at RESET_PC immediately.
    rst = 1'b0;
    #1;
    check("release.imem_req", {31'd0, bus.imem_req}, 32'd1);
    check("release.imem_addr", bus.imem_addr, 32'd0);

    // Back-to-back acks: 0, 4.
    drive(1'b1, mem(32'h0), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("seq0", 1'b1, 32'h0, mem(32'h0), 1'b1, 32'h4);
    drive(1'b1, mem(32'h4), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("seq4", 1'b1, 32'h4, mem(32'h4), 1'b1, 32'h8);

    // Load stall 3 cycles; the word at 8 arrives in the first one.
    drive(1'b1, mem(32'h8), 1'b1, 1'b0, 1'b0, 1'b0); tick();
    expect_out("stall1", 1'b1, 32'h4, mem(32'h4), 1'b0, 32'hC);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    expect_out("stall2", 1'b1, 32'h4, mem(32'h4), 1'b0, 32'hC);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    expect_out("stall3", 1'b1, 32'h4, mem(32'h4), 1'b0, 32'hC);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("unstall8", 1'b1, 32'h8, mem(32'h8), 1'b1, 32'hC);
    drive(1'b1, mem(32'hC), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("seq12", 1'b1, 32'hC, mem(32'hC), 1'b1, 32'h10);

    // Jal with ack: data from 16 discarded.
    jal_target = 32'h100;
    drive(1'b1, mem(32'h10), 1'b0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("jal", 1'b0, 32'd0, 32'd0, 1'b1, 32'h100);
    drive(1'b1, mem(32'h100), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("jal_tgt", 1'b1, 32'h100, mem(32'h100), 1'b1, 32'h104);

    // Stall without ack: outputs hold, request stays up.
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    expect_out("stall_noack", 1'b1, 32'h100, mem(32'h100), 1'b1, 32'h104);

    // Branch while ack withheld 2 cycles: drain old address.
    branch_target = 32'h40;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    expect_out("drain1", 1'b0, 32'd0, 32'd0, 1'b1, 32'h104);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("drain2", 1'b0, 32'd0, 32'd0, 1'b1, 32'h104);
    drive(1'b1, mem(32'h104), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("drain_ack", 1'b0, 32'd0, 32'd0, 1'b1, 32'h40);
    drive(1'b1, mem(32'h40), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("br_tgt", 1'b1, 32'h40, mem(32'h40), 1'b1, 32'h44);

    // Jal + Jalr + load together: Jalr wins, aligned, no stall.
    jal_target  = 32'h200;
    jalr_target = 32'h302;
    drive(1'b1, mem(32'h44), 1'b1, 1'b1, 1'b1, 1'b0); tick();
    expect_out("prio", 1'b0, 32'd0, 32'd0, 1'b1, 32'h300);
    drive(1'b1, mem(32'h300), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("prio_tgt", 1'b1, 32'h300, mem(32'h300), 1'b1, 32'h304);

    // No ack, no load: bubble.
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("bubble", 1'b0, 32'd0, 32'd0, 1'b1, 32'h304);

    // Enter HOLD with the word at 0x304 buffered, then reset.
    drive(1'b1, mem(32'h304), 1'b1, 1'b0, 1'b0, 1'b0); tick();
    expect_out("hold", 1'b0, 32'd0, 32'd0, 1'b0, 32'h308);
    rst = 1'b1;
    drive(1'b1, mem(32'h308), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("rst_hold", 1'b0, 32'd0, 32'd0, 1'b0, 32'h0);
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rerelease.imem_req", {31'd0, bus.imem_req}, 32'd1);
    check("rerelease.imem_addr", bus.imem_addr, 32'd0);
    tick();
    expect_out("post_rst", 1'b0, 32'd0, 32'd0, 1'b1, 32'h0);
    drive(1'b1, mem(32'h0), 1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_out("post_rst_fetch", 1'b1, 32'h0, mem(32'h0), 1'b1, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port Jal, Jalr, branch_result  input  1 each  redirect requests from execute.
REQ-005 SHALL have port jal_target, jalr_target, branch_target  input  32 each  redirect addresses.
REQ-006 SHALL have port load  input  1  load-use stall; fetch outputs hold.
REQ-007 SHALL have port imem_req  output  1  instruction-memory request.
REQ-008 SHALL have port imem_addr  output  32  request address.
REQ-009 SHALL have port imem_ack  input  1  read data valid, ends the request.
REQ-010 SHALL have port imem_rdata  input  32  read instruction.
REQ-011 SHALL have port instruction_fetch  output  32  fetched instruction to the IF/ID register.
REQ-012 SHALL have port pc_pre_address  output  32  address of instruction_fetch.
REQ-013 SHALL have port fetch_valid  output  1  instruction_fetch holds a real instruction.

Function
REQ-014 SHALL keep internal pc (next fetch address), buffer buf/buf_pc, redirect register redir_pc, and FSM states FETCH, HOLD, DRAIN.
REQ-015 SHALL force bits [1:0] of every loaded pc or redir_pc value to 0.
REQ-016 SHALL prioritise redirects Jalr > Jal > branch_result when several are asserted together.
REQ-017 SHALL give any redirect priority over load in the same cycle.
REQ-018 SHALL, in FETCH, drive imem_req=1 and imem_addr=pc.
REQ-019 SHALL hold imem_addr stable while imem_req=1 until imem_ack, in every state.
REQ-020 SHALL, in FETCH with ack, no redirect and no load, register rdata/pc to instruction_fetch/pc_pre_address, set fetch_valid=1, pc<=pc+4 (wraps mod 2^32); outputs valid next cycle.
REQ-021 SHALL, in FETCH with ack and load, set buf<=rdata, buf_pc<=pc, pc<=pc+4, go HOLD, and leave outputs unchanged.
REQ-022 SHALL, in FETCH without ack and load=1, keep outputs unchanged and keep the request asserted.
REQ-023 SHALL, in FETCH without ack and load=0, drive outputs to 0 and fetch_valid=0 (bubble).
REQ-024 SHALL, in HOLD, drive imem_req=0.
REQ-025 SHALL, in HOLD with load=0, load outputs from buf/buf_pc, set fetch_valid=1, and go FETCH.
REQ-026 SHALL, in HOLD with load=1, stay in HOLD with outputs unchanged.
REQ-027 SHALL, on redirect in FETCH with ack, discard rdata, set pc<=target, zero outputs with fetch_valid=0, and stay FETCH.
REQ-028 SHALL, on redirect in FETCH without ack, set redir_pc<=target, zero outputs, and go DRAIN.
REQ-029 SHALL, on redirect in HOLD, discard buf, set pc<=target, zero outputs, and go FETCH.
REQ-030 SHALL, in DRAIN, keep imem_req=1 at the old address, drive outputs 0, and on ack discard rdata, set pc<=redir_pc, and go FETCH.
REQ-031 SHALL, on a new redirect in DRAIN, overwrite redir_pc (latest wins), including in the ack cycle, where the new target is used.

Reset
REQ-032 SHALL, while rst=1, set pc=RESET_PC, state=FETCH, instruction_fetch=0, pc_pre_address=0, fetch_valid=0, imem_req=0, buf=0, redir_pc=0.
REQ-033 SHALL give rst priority over all inputs; rst mid-request abandons the request and ignores any ack in the rst cycle.
REQ-034 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after rst deasserts.

Verification
REQ-035 SHALL verify: reset release, ack every cycle with rdata=addr^32'hFFFF_FFFF -> pc_pre_address sequence 0,4,8; each instruction_fetch matches; fetch_valid=1 from the second cycle.
REQ-036 SHALL verify: load=1 for 3 cycles with ack at addr 8 -> outputs frozen; after load drops, instruction from addr 8 appears once, then fetch resumes at 12 with none lost or duplicated.
REQ-037 SHALL verify: Jal=1 with jal_target=32'h100 in a cycle with ack -> next cycle fetch_valid=0, imem_addr=32'h100; the discarded data never appears.
REQ-038 SHALL verify: branch_result=1 (target 32'h40) while ack is withheld 2 cycles -> DRAIN holds old imem_addr until ack; the next request goes to 32'h40.
REQ-039 SHALL verify: Jal and Jalr and load in one cycle (targets 32'h200/32'h302) -> redirect to 32'h300, no stall.
REQ-040 SHALL verify: rst=1 while in HOLD -> next cycle all outputs 0 and imem_addr=RESET_PC; a buffered instruction never appears.
